// File: rtl/tetris_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : tetris_pkg                                                      |
// | Brief    : Shared board geometry, line-clear FSM encoding, score function. |
// |            Define SCORE_BONUS_EN for the multi-line bonus score table.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package tetris_pkg;

    localparam int c_ROWS  = 20;
    localparam int c_COLS  = 10;
    localparam int c_CNT_W = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_FLASH   = 3'd2,
        S_COMPACT = 3'd3,
        S_FILL    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic logic [7:0] scoreAdd(input logic [5:0] k);
`ifdef SCORE_BONUS_EN
        logic [7:0] v;
        case (k)
            6'd0:    v = 8'd0;
            6'd1:    v = 8'd1;
            6'd2:    v = 8'd3;
            6'd3:    v = 8'd5;
            default: v = {1'b0, k, 1'b0};
        endcase
        return v;
`else
        return {2'b00, k};
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/flash_timer.sv
// +----------------------------------------------------------------------------+
// | Module   : flash_timer                                                     |
// | Brief    : Loadable down-counter; expired is high on the last counted cycle.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module flash_timer #(
    parameter int CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic expired
);

    localparam int             c_W    = $clog2(CYCLES + 1);
    localparam logic [c_W-1:0] c_LOAD = c_W'(CYCLES);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= c_LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign expired = (r_count == c_ONE);

endmodule

`default_nettype wire

// File: rtl/line_clear_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : line_clear_ctrl                                                 |
// | Brief    : Scans for full rows, flashes them, compacts the board, zero-    |
// |            fills the top and updates the score (SCORE_BONUS_EN selectable).|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS         = c_ROWS,
    parameter int COLS         = c_COLS,
    parameter int FLASH_CYCLES = 25_000_000,
    parameter int SCORE_MAX    = 99
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clr_score,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_row,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [4:0]      wr_row,
    output logic [COLS-1:0] wr_data,
    output logic [ROWS-1:0] flash_rows,
    output logic [4:0]      lines,
    output logic [6:0]      score
);

    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(ROWS - 1);
    localparam logic [c_CNT_W-1:0] c_NROWS   = c_CNT_W'(ROWS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [ROWS-1:0]    c_ONE     = ROWS'(1);
    localparam logic [7:0]         c_SMAX    = 8'(SCORE_MAX);
    localparam logic [6:0]         c_SMAX7   = 7'(SCORE_MAX);

    state_t             r_state;
    state_t             w_nextState;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_dst;
    logic [ROWS-1:0]    r_fullMask;
    logic [4:0]         r_lines;
    logic [6:0]         r_score;

    logic [4:0]         w_rdIdx;
    logic [c_CNT_W-1:0] w_dataIdx;
    logic [ROWS-1:0]    w_dataSel;
    logic               w_dataFull;
    logic               w_scanEnd;
    logic [ROWS-1:0]    w_scanMask;
    logic [c_CNT_W-1:0] w_k;
    logic [7:0]         w_sum;
    logic [6:0]         w_newScore;
    logic               w_timerStart;
    logic               w_expired;

    // Read data returning this cycle belongs to the row addressed on the previous count.
    assign w_rdIdx    = 5'(c_LAST - r_cnt);
    assign w_dataIdx  = c_NROWS - r_cnt;
    assign w_dataSel  = c_ONE << w_dataIdx;
    assign w_dataFull = |(r_fullMask & w_dataSel);
    assign w_scanEnd  = (r_cnt == c_NROWS);
    assign w_scanMask = ((r_cnt != '0) && (&rd_data)) ? (r_fullMask | w_dataSel) : r_fullMask;

    always_comb begin
        w_k = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_k = w_k + {{(c_CNT_W-1){1'b0}}, r_fullMask[i]};
        end
    end

    assign w_sum      = {1'b0, r_score} + scoreAdd(w_k);
    assign w_newScore = (w_sum > c_SMAX) ? c_SMAX7 : w_sum[6:0];

    assign w_timerStart = (r_state == S_SCAN) && w_scanEnd && (w_scanMask != '0);

    flash_timer #(
        .CYCLES (FLASH_CYCLES)
    ) u_flashTimer (
        .clk     (clk),
        .rst     (rst),
        .start   (w_timerStart),
        .expired (w_expired)
    );

    always_comb begin
        w_nextState = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        rd_row      = '0;
        wr_en       = 1'b0;
        wr_row      = '0;
        wr_data     = '0;
        flash_rows  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_SCAN;
            end
            S_SCAN: begin
                if (!w_scanEnd) rd_row = w_rdIdx;
                else            w_nextState = (w_scanMask == '0) ? S_DONE : S_FLASH;
            end
            S_FLASH: begin
                flash_rows = r_fullMask;
                if (w_expired) w_nextState = S_COMPACT;
            end
            S_COMPACT: begin
                if (!w_scanEnd) rd_row = w_rdIdx;
                if ((r_cnt != '0) && !w_dataFull) begin
                    wr_en   = 1'b1;
                    wr_row  = r_dst[4:0];
                    wr_data = rd_data;
                end
                if (w_scanEnd) w_nextState = S_FILL;
            end
            S_FILL: begin
                wr_en  = 1'b1;
                wr_row = r_cnt[4:0];
                if ((r_cnt + c_CNT_ONE) == w_k) w_nextState = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dst      <= '0;
            r_fullMask <= '0;
            r_lines    <= '0;
            r_score    <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_dst <= c_LAST;
                    if (start) r_fullMask <= '0;
                end
                S_SCAN: begin
                    r_fullMask <= w_scanMask;
                    r_cnt      <= w_scanEnd ? '0 : r_cnt + c_CNT_ONE;
                end
                S_FLASH: begin
                    r_cnt <= '0;
                end
                S_COMPACT: begin
                    if ((r_cnt != '0) && !w_dataFull) r_dst <= r_dst - c_CNT_ONE;
                    r_cnt <= w_scanEnd ? '0 : r_cnt + c_CNT_ONE;
                end
                S_FILL: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                S_DONE: begin
                    r_lines <= w_k[4:0];
                end
                default: ;
            endcase
            // A new-game clear overrides the end-of-sequence add.
            if (clr_score)              r_score <= '0;
            else if (r_state == S_DONE) r_score <= w_newScore;
        end
    end

    assign lines = r_lines;
    assign score = r_score;

endmodule

`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_line_clear_ctrl                                              |
// | Brief    : Scoreboard bench for line_clear_ctrl with a 1-cycle row store.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int FC   = 4;
    localparam int SMAX = 99;
    localparam logic [COLS-1:0] FULL = '1;

    typedef struct {
        logic [4:0]           lines;
        logic [6:0]           score;
        logic [ROWS*COLS-1:0] board;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            clr_score = 1'b0;
    logic            busy, done, wr_en;
    logic [4:0]      rd_row, wr_row, lines;
    logic [COLS-1:0] rd_data, wr_data;
    logic [ROWS-1:0] flash_rows;
    logic [6:0]      score;

    logic [COLS-1:0] mem   [ROWS];
    logic [COLS-1:0] ldMem [ROWS];
    logic            ldEn = 1'b0;

    int   nChecks = 0;
    int   nFails  = 0;
    int   mScore  = 0;
    exp_t sbQ[$];
    exp_t popE;
    bit   donePrev = 1'b0;

    always #5 clk = ~clk;

    line_clear_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .FLASH_CYCLES (FC),
        .SCORE_MAX    (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clr_score  (clr_score),
        .busy       (busy),
        .done       (done),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .flash_rows (flash_rows),
        .lines      (lines),
        .score      (score)
    );

    always @(posedge clk) begin
        if (ldEn) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= ldMem[i];
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
        rd_data <= mem[rd_row];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int addK(input int k);
`ifdef SCORE_BONUS_EN
        if (k == 0) return 0;
        if (k == 1) return 1;
        if (k == 2) return 3;
        if (k == 3) return 5;
        return 2 * k;
`else
        return k;
`endif
    endfunction

    always @(negedge clk) begin
        if (donePrev) begin
            if (sbQ.size() == 0) begin
                chk("sb_unexpected_done", 32'd0, 32'd1);
            end else begin
                popE = sbQ.pop_front();
                chk("lines", 32'(lines), 32'(popE.lines));
                chk("score", 32'(score), 32'(popE.score));
                for (int r = 0; r < ROWS; r++)
                    chk($sformatf("board_row%0d", r), 32'(mem[r]), 32'(popE.board[r*COLS +: COLS]));
            end
        end
        donePrev = (done === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic loadBoard();
        @(negedge clk) ldEn = 1'b1;
        @(negedge clk) ldEn = 1'b0;
    endtask

    task automatic buildBoard(input int k, input int off);
        logic [COLS-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v = COLS'($urandom);
            if (v == FULL) v[0] = 1'b0;
            ldMem[r] = (((r + off) % ROWS) < k) ? FULL : v;
        end
        loadBoard();
    endtask

    task automatic computeExp(output exp_t e, output int k, output logic [ROWS-1:0] mask);
        int dst;
        dst     = ROWS - 1;
        e.board = '0;
        k       = 0;
        mask    = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (ldMem[r] == FULL) begin
                k++;
                mask[r] = 1'b1;
            end else begin
                e.board[dst*COLS +: COLS] = ldMem[r];
                dst--;
            end
        end
        e.lines = 5'(k);
        e.score = '0;
    endtask

    task automatic runSeq(input bit spurious, input bit clrAtDone);
        exp_t            e;
        int              k;
        logic [ROWS-1:0] mask;
        int              doneCnt, doneCycle, flashCnt, wrCnt, expDone;
        bit              maskChecked;
        doneCnt = 0; doneCycle = -1; flashCnt = 0; wrCnt = 0; maskChecked = 1'b0;
        computeExp(e, k, mask);
        if (clrAtDone) mScore = 0;
        else           mScore = (mScore + addK(k) > SMAX) ? SMAX : mScore + addK(k);
        e.score = 7'(mScore);
        sbQ.push_back(e);
        expDone = (k == 0) ? ROWS + 2 : 2 * ROWS + 3 + FC + k;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                chk("busy_after_start", 32'(busy), 32'd1);
            end
            if (spurious && (n == 23 || n == 30))      start = 1'b1;
            else if (spurious && (n == 24 || n == 31)) start = 1'b0;
            if (flash_rows != '0) begin
                flashCnt++;
                if (!maskChecked) begin
                    chk("flash_mask", 32'(flash_rows), 32'(mask));
                    maskChecked = 1'b1;
                end
            end
            if (wr_en) wrCnt++;
            if (clr_score) clr_score = 1'b0;
            if (done) begin
                doneCnt++;
                if (doneCycle < 0) begin
                    doneCycle = n;
                    if (clrAtDone) clr_score = 1'b1;
                end
            end
            if (doneCycle >= 0 && n >= doneCycle + 2) break;
        end
        chk("done_count", 32'(doneCnt), 32'd1);
        chk("done_cycle", 32'(doneCycle), 32'(expDone));
        chk("flash_cycles", 32'(flashCnt), (k == 0) ? 32'd0 : 32'(FC));
        chk("write_count", 32'(wrCnt), (k == 0) ? 32'd0 : 32'(ROWS));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int need, k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_wr_en", 32'(wr_en),      32'd0);
        chk("rst_rdrow", 32'(rd_row),     32'd0);
        chk("rst_wrrow", 32'(wr_row),     32'd0);
        chk("rst_wdata", 32'(wr_data),    32'd0);
        chk("rst_flash", 32'(flash_rows), 32'd0);
        chk("rst_lines", 32'(lines),      32'd0);
        chk("rst_score", 32'(score),      32'd0);
        rst = 1'b1;

        // Rows 19 and 17 full, row 18 one cell short
        for (int r = 0; r < ROWS; r++) ldMem[r] = COLS'(r * 37 + 5);
        ldMem[19] = FULL;
        ldMem[18] = FULL ^ 10'h001;
        ldMem[17] = FULL;
        loadBoard();
        runSeq(1'b0, 1'b0);

        // No full rows
        buildBoard(0, 0);
        runSeq(1'b0, 1'b0);

        // Climb to 98 then saturate at 99
        @(negedge clk) clr_score = 1'b1;
        @(negedge clk) clr_score = 1'b0;
        mScore = 0;
        chk("clr_idle", 32'(score), 32'd0);
        for (int it = 0; it < 10 && mScore < 98; it++) begin
            need = 98 - mScore;
            k = ROWS;
            while (k > 0 && addK(k) > need) k--;
            buildBoard(k, int'($urandom_range(0, ROWS - 1)));
            runSeq(1'b0, 1'b0);
        end
        chk("score_98", 32'(score), 32'd98);
        buildBoard(4, 3);
        runSeq(1'b0, 1'b0);
        chk("score_sat", 32'(score), 32'd99);
        buildBoard(ROWS, 0);
        runSeq(1'b0, 1'b0);
        chk("score_hold", 32'(score), 32'd99);

        // Start pulses during FLASH and COMPACT are ignored
        buildBoard(2, 5);
        runSeq(1'b1, 1'b0);

        // Reset in the middle of COMPACT
        for (int r = 0; r < ROWS; r++) ldMem[r] = COLS'(r * 11 + 2);
        ldMem[19] = FULL;
        ldMem[17] = FULL;
        loadBoard();
        @(negedge clk) start = 1'b1;
        for (int n = 1; n < 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en),      32'd0);
        chk("arst_busy",  32'(busy),       32'd0);
        chk("arst_done",  32'(done),       32'd0);
        chk("arst_flash", 32'(flash_rows), 32'd0);
        chk("arst_rdrow", 32'(rd_row),     32'd0);
        chk("arst_wrrow", 32'(wr_row),     32'd0);
        chk("arst_lines", 32'(lines),      32'd0);
        chk("arst_score", 32'(score),      32'd0);
        mScore = 0;
        @(negedge clk) rst = 1'b1;
        buildBoard(3, 11);
        runSeq(1'b0, 1'b0);

        // Score clear coincident with done
        buildBoard(3, 7);
        runSeq(1'b0, 1'b1);
        chk("clr_at_done", 32'(score), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
